// File: rtl/riscv_pipe_pkg.sv
// Shared types and default widths for the 5-stage pipeline memory port arbiter.
package riscv_pipe_pkg;
  localparam int XLEN         = 64;
  localparam int ILEN         = 32;
  localparam int ADDR_W       = 64;
  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// IF/MEM arbiter for one shared single-port memory; one transaction in flight.
// Optional fetch starvation guard enabled by defining ARB_FETCH_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int XLEN         = riscv_pipe_pkg::XLEN,
  parameter int ILEN         = riscv_pipe_pkg::ILEN,
  parameter int ADDR_W       = riscv_pipe_pkg::ADDR_W,
  parameter int STARVE_LIMIT = riscv_pipe_pkg::STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  output logic [ILEN-1:0]   if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              stall
);
  import riscv_pipe_pkg::*;

  arb_state_t        r_state, w_next;
  arb_owner_t        r_owner;
  logic              r_drop;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic              w_grant_dm, w_grant_if, w_force_if;

`ifdef ARB_FETCH_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] r_streak;

  // Counts DM grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!reset)                                         r_streak <= '0;
    else if (!if_req || w_grant_if)                     r_streak <= '0;
    else if (w_grant_dm && !flush && r_streak != LIM)   r_streak <= r_streak + 1'b1;
  end

  assign w_force_if = (r_streak == LIM) & if_req & ~flush;
`else
  logic w_unused_lim;
  assign w_unused_lim = ^STARVE_LIMIT;
  assign w_force_if   = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_grant_dm = 1'b0;
    w_grant_if = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_req && !w_force_if)  w_grant_dm = 1'b1;
        else if (if_req && !flush)  w_grant_if = 1'b1;
        if (w_grant_dm || w_grant_if) w_next = ST_REQ;
      end
      ST_REQ:  if (mem_gnt)    w_next = ST_WAIT;
      ST_WAIT: if (mem_rvalid) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_drop  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_dm) begin
            r_owner <= OWN_DM;
            r_addr  <= dm_addr;
            r_we    <= dm_we;
            r_wdata <= dm_wdata;
          end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr;
            r_we    <= 1'b0;
            r_wdata <= '0;
          end
        end
        // A cancelled fetch still drains on the memory side; only its done pulse is dropped.
        ST_REQ, ST_WAIT: begin
          if (flush && r_owner == OWN_IF) r_drop <= 1'b1;
          if (r_state == ST_WAIT && mem_rvalid) r_rdata <= mem_rdata;
        end
        ST_DONE: begin
          r_owner <= OWN_NONE;
          r_drop  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = reset & (r_state == ST_REQ);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr  : '0;
  assign mem_wdata = mem_req ? r_wdata : '0;

  assign if_done  = reset & (r_state == ST_DONE) & (r_owner == OWN_IF) & ~r_drop;
  assign dm_done  = reset & (r_state == ST_DONE) & (r_owner == OWN_DM);
  assign if_rdata = !if_done ? '0 : (r_addr[2] ? r_rdata[2*ILEN-1:ILEN] : r_rdata[ILEN-1:0]);
  assign dm_rdata = dm_done ? r_rdata : '0;

  assign stall = reset & ((if_req & ~if_done & ~flush) | (dm_req & ~dm_done));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written corner sequences.
module tb_mem_port_arbiter;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, flush, dm_req, dm_we, mem_gnt, mem_rvalid;
  logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic        if_done, dm_done, mem_req, mem_we, stall;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;  logic [63:0] ia; logic fl;
    logic        dr;  logic dw; logic [63:0] da; logic [63:0] dd;
    logic        g;   logic rv; logic [63:0] rd;
    logic        e_mreq; logic e_mwe; logic [63:0] e_maddr; logic [63:0] e_mwdata;
    logic        e_ifd; logic [31:0] e_ifr; logic e_dmd; logic [63:0] e_dmr; logic e_stall;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic ir, input logic [63:0] ia, input logic fl,
    input logic dr, input logic dw, input logic [63:0] da, input logic [63:0] dd,
    input logic g, input logic rv, input logic [63:0] rd,
    input logic e_mreq, input logic e_mwe, input logic [63:0] e_maddr, input logic [63:0] e_mwdata,
    input logic e_ifd, input logic [31:0] e_ifr, input logic e_dmd, input logic [63:0] e_dmr,
    input logic e_stall);
    vec_t v;
    v.ir = ir; v.ia = ia; v.fl = fl; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.g = g; v.rv = rv; v.rd = rd;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.e_ifd = e_ifd; v.e_ifr = e_ifr; v.e_dmd = e_dmd; v.e_dmr = e_dmr; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    if_req = L; if_addr = '0; flush = L;
    dm_req = L; dm_we = L; dm_addr = '0; dm_wdata = '0;
    mem_gnt = L; mem_rvalid = L; mem_rdata = '0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_req"},  {63'd0, mem_req},  64'd0);
    chk({tag, " mem_we"},   {63'd0, mem_we},   64'd0);
    chk({tag, " mem_addr"}, mem_addr,          64'd0);
    chk({tag, " mem_wdata"}, mem_wdata,        64'd0);
    chk({tag, " if_done"},  {63'd0, if_done},  64'd0);
    chk({tag, " if_rdata"}, {32'd0, if_rdata}, 64'd0);
    chk({tag, " dm_done"},  {63'd0, dm_done},  64'd0);
    chk({tag, " dm_rdata"}, dm_rdata,          64'd0);
    chk({tag, " stall"},    {63'd0, stall},    64'd0);
  endtask

  int   dm_n, dm_before_if;
  logic if_seen, pend, pend_n;

  initial begin
    idle_in();
    reset = L;
    if_req = H; dm_req = H; if_addr = 64'h104; dm_addr = 64'h200;

    // Reset: every output masked even with both requests up
    @(negedge clk);
    chk_all_zero("reset");
    next_cyc();
    reset = H;
    idle_in();

    // Test 1: fetch; test 2: DM beats IF; test 3: delayed-grant store with stray rvalid/gnt
    tv.push_back(mk(H,64'h104,L, L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h104,L, L,L,64'h0,64'h0, H,L,64'h0, H,L,64'h104,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h104,L, L,L,64'h0,64'h0, L,H,64'hAAAA_BBBB_CCCC_DDDD, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h104,L, L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, H,32'hAAAA_BBBB,L,64'h0,L));
    tv.push_back(mk(L,64'h0,L,   L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,L));

    tv.push_back(mk(H,64'h10,L, H,L,64'h200,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, H,L,64'h200,64'h0, H,L,64'h0, H,L,64'h200,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, H,L,64'h200,64'h0, L,H,64'h1111_2222_3333_4444, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, H,L,64'h200,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,H,64'h1111_2222_3333_4444,H));
    tv.push_back(mk(H,64'h10,L, L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, L,L,64'h0,64'h0, H,L,64'h0, H,L,64'h10,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, L,L,64'h0,64'h0, L,H,64'h5555_6666_7777_8888, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(H,64'h10,L, L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, H,32'h7777_8888,L,64'h0,L));
    tv.push_back(mk(L,64'h0,L,  L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,L));

    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,L,64'h0, H,H,64'h80,64'h1234, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,H,64'hDEAD, H,H,64'h80,64'h1234, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,L,64'h0, H,H,64'h80,64'h1234, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, H,L,64'h0, H,H,64'h80,64'h1234, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, H,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,H,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,H));
    tv.push_back(mk(L,64'h0,L, H,H,64'h80,64'h1234, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,H,64'h0,L));
    tv.push_back(mk(L,64'h0,L, L,L,64'h0,64'h0, L,L,64'h0, L,L,64'h0,64'h0, L,32'h0,L,64'h0,L));

    foreach (tv[i]) begin
      if_req = tv[i].ir; if_addr = tv[i].ia; flush = tv[i].fl;
      dm_req = tv[i].dr; dm_we = tv[i].dw; dm_addr = tv[i].da; dm_wdata = tv[i].dd;
      mem_gnt = tv[i].g; mem_rvalid = tv[i].rv; mem_rdata = tv[i].rd;
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i),   {63'd0, mem_req},  {63'd0, tv[i].e_mreq});
      chk($sformatf("row%0d mem_we", i),    {63'd0, mem_we},   {63'd0, tv[i].e_mwe});
      chk($sformatf("row%0d mem_addr", i),  mem_addr,          tv[i].e_maddr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,         tv[i].e_mwdata);
      chk($sformatf("row%0d if_done", i),   {63'd0, if_done},  {63'd0, tv[i].e_ifd});
      chk($sformatf("row%0d if_rdata", i),  {32'd0, if_rdata}, {32'd0, tv[i].e_ifr});
      chk($sformatf("row%0d dm_done", i),   {63'd0, dm_done},  {63'd0, tv[i].e_dmd});
      chk($sformatf("row%0d dm_rdata", i),  dm_rdata,          tv[i].e_dmr);
      chk($sformatf("row%0d stall", i),     {63'd0, stall},    {63'd0, tv[i].e_stall});
      next_cyc();
    end
    idle_in();

    // Test 4: flush in IDLE blocks the grant; flush in WAIT swallows if_done
    if_req = H; if_addr = 64'h300; flush = H;
    @(negedge clk); chk("t4 flush idle stall", {63'd0, stall}, 64'd0);
    next_cyc(); flush = L;
    @(negedge clk); chk("t4 flush idle no grant", {63'd0, mem_req}, 64'd0);
    next_cyc(); mem_gnt = H;
    @(negedge clk); chk("t4 req addr", mem_addr, 64'h300);
    next_cyc(); mem_gnt = L; flush = H;
    @(negedge clk); chk("t4 flush stall", {63'd0, stall}, 64'd0);
    next_cyc(); flush = L; if_addr = 64'h400; mem_rvalid = H; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk); chk("t4 wait stall", {63'd0, stall}, 64'd1);
    next_cyc(); mem_rvalid = L; mem_rdata = '0;
    @(negedge clk);
    chk("t4 dropped if_done", {63'd0, if_done}, 64'd0);
    chk("t4 dropped if_rdata", {32'd0, if_rdata}, 64'd0);
    next_cyc();
    @(negedge clk); chk("t4 idle mem_req", {63'd0, mem_req}, 64'd0);
    next_cyc(); mem_gnt = H;
    @(negedge clk);
    chk("t4 new req", {63'd0, mem_req}, 64'd1);
    chk("t4 new addr", mem_addr, 64'h400);
    next_cyc(); mem_gnt = L; mem_rvalid = H; mem_rdata = 64'h0000_0001_0000_0002;
    next_cyc(); mem_rvalid = L;
    @(negedge clk);
    chk("t4 new if_done", {63'd0, if_done}, 64'd1);
    chk("t4 new if_rdata", {32'd0, if_rdata}, 64'h2);
    next_cyc(); idle_in();

    // Test 5: reset mid-WAIT, late rvalid ignored afterwards
    dm_req = H; dm_addr = 64'h500;
    next_cyc(); mem_gnt = H;
    @(negedge clk); chk("t5 req", {63'd0, mem_req}, 64'd1);
    next_cyc(); mem_gnt = L; reset = L;
    @(negedge clk); chk_all_zero("t5 in reset");
    next_cyc(); reset = H; dm_req = L; mem_rvalid = H; mem_rdata = 64'h5A5A;
    @(negedge clk); chk_all_zero("t5 late rvalid");
    next_cyc(); mem_rvalid = L; mem_rdata = '0;
    @(negedge clk); chk_all_zero("t5 after");
    dm_req = H; dm_addr = 64'h540;
    next_cyc();
    @(negedge clk);
    chk("t5 idle fresh req", {63'd0, mem_req}, 64'd1);
    chk("t5 idle fresh addr", mem_addr, 64'h540);
    mem_gnt = H;
    next_cyc(); mem_gnt = L; mem_rvalid = H;
    next_cyc(); mem_rvalid = L; dm_req = L;
    next_cyc(); idle_in();

    // Test 6: continuous DM traffic against a waiting fetch
    if_req = H; if_addr = 64'h600; dm_req = H; dm_addr = 64'h700;
    dm_n = 0; dm_before_if = -1; if_seen = L; pend = L;
    for (int c = 0; c < 40; c++) begin
      mem_gnt = mem_req; mem_rvalid = pend; pend_n = mem_req;
      @(negedge clk);
      if (mem_req) begin
        if (mem_addr == 64'h600) begin
          if (!if_seen) dm_before_if = dm_n;
          if_seen = H;
        end else dm_n++;
      end
      if (if_done) if_req = L;
      next_cyc();
      pend = pend_n;
    end
`ifdef ARB_FETCH_STARVE_GUARD_EN
    chk("t6 guard if granted", {63'd0, if_seen}, 64'd1);
    chk("t6 guard dm before if", 64'(dm_before_if), 64'd4);
`else
    chk("t6 strict if never granted", {63'd0, if_seen}, 64'd0);
    chk("t6 strict dm count", 64'(dm_n), 64'd10);
`endif
    idle_in();
    next_cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
